// File: rtl/seq_gen_pkg.sv
// Shared definitions for the programmable sequence generator.
package seq_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Ceiling log2, used to size the table index from DEPTH.
  function automatic int seq_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_table.sv
// DEPTH x WIDTH sequence table: one write port, one combinational read port.
// Reset loads the identity pattern (entry i = i mod 2^WIDTH).
module seq_table
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage: identity pattern on reset, otherwise accept in-range writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= WIDTH'(i);
      end
    end else if (wr_en_i && (int'(wr_addr_i) < DEPTH)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port; out-of-range addresses read as zero.
  always_comb begin
    rd_data_o = '0;
    if (int'(rd_addr_i) < DEPTH) begin
      rd_data_o = mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/seq_gen.sv
// Programmable sequence generator: steps an index through a writable table
// with prescaling, direction, loop/one-shot mode and wrap/done pulses.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int DEPTH   = 8,
  parameter int PRESC_W = 8,
  localparam int AW     = seq_clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_loop,
  input  logic               dir,
  input  logic [AW-1:0]      last_idx,
  input  logic [PRESC_W-1:0] presc,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  output logic [WIDTH-1:0]   seq_out,
  output logic [AW-1:0]      idx,
  output logic               running,
  output logic               wrap,
  output logic               done
);

  state_t             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;

  logic [AW-1:0]      eff_last;
  logic [AW-1:0]      start_pos;
  logic [AW-1:0]      step_idx;
  logic               at_end;
  logic [WIDTH-1:0]   rd_data;

  seq_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (idx_d),
    .rd_data_o (rd_data)
  );

  // Clamp the programmed length to the table and derive the step candidates.
  always_comb begin
    eff_last = last_idx;
    if (int'(last_idx) > DEPTH - 1) begin
      eff_last = AW'(DEPTH - 1);
    end
    start_pos = dir ? eff_last : '0;
    if (dir) begin
      at_end   = (idx_q == '0);
      step_idx = (idx_q > eff_last) ? eff_last : idx_q - 1'b1;
    end else begin
      at_end   = (idx_q >= eff_last);
      step_idx = idx_q + 1'b1;
    end
  end

  // FSM next state, prescaler and index update; pulses default low.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
          idx_d   = start_pos;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          idx_d = start_pos;
          cnt_d = '0;
        end else if (en) begin
          if (cnt_q >= presc) begin
            cnt_d = '0;
            if (at_end) begin
              if (mode_loop) begin
                idx_d  = start_pos;
                wrap_d = 1'b1;
              end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              idx_d = step_idx;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output data follows the next index; a same-cycle write to it is forwarded.
  always_comb begin
    out_d = rd_data;
    if (wr_en && (wr_addr == idx_d)) begin
      out_d = wr_data;
    end
  end

  // State, prescaler and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign seq_out = out_q;
  assign idx     = idx_q;
  assign running = (state_q == ST_RUN);
  assign wrap    = wrap_q;
  assign done    = done_q;

endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
Programmable sequence generator: the parametrised successor of the team's fixed 3-bit hard-coded-sequence state machine. Steps an index through a writable DEPTH x WIDTH sequence table and presents the selected entry on a registered output. Adds the following over the fixed machine: prescaled stepping, up/down direction, loop or one-shot mode, programmable length, start/stop control, and wrap/done pulses. Sits between control logic (register block or top-level FSM) and whatever consumes the pattern (display, mux select, stimulus).

Parameters:
WIDTH, 3, bit width of each sequence entry and of seq_out
DEPTH, 8, number of table entries (>=2); AW = clog2(DEPTH)
PRESC_W, 8, width of prescaler compare value

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  clock enable for prescaler/stepping; 0 freezes RUN progress
start  input  1  start/restart pulse
stop  input  1  stop pulse; wins over start
mode_loop  input  1  1 = wrap and continue, 0 = one-shot
dir  input  1  0 = up (0 -> last), 1 = down (last -> 0)
last_idx  input  AW  index of final entry (sequence length - 1)
presc  input  PRESC_W  step every presc+1 enabled cycles
wr_en  input  1  table write strobe
wr_addr  input  AW  table write address
wr_data  input  WIDTH  table write data
seq_out  output  WIDTH  registered table[idx]
idx  output  AW  current index
running  output  1  1 while in RUN
wrap  output  1  1-cycle pulse on loop wrap
done  output  1  1-cycle pulse on one-shot completion

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, idx=0, presc_cnt=0, running=0, wrap=0, done=0; table entry i = i mod 2^WIDTH; seq_out=0. Mid-operation reset aborts RUN and restores the table.
- States: IDLE, RUN. running = (state==RUN).
- Effective last: eff_last = min(last_idx, DEPTH-1).
- IDLE: idx and seq_out hold. start=1 and stop=0 -> RUN; idx <= (dir ? eff_last : 0); presc_cnt <= 0.
- RUN, stop=1 -> IDLE; idx and seq_out hold; no done pulse.
- RUN, start=1 (stop=0): restart exactly as from IDLE.
- RUN, en=0: everything frozen.
- RUN, en=1: if presc_cnt >= presc, then presc_cnt <= 0 and step; else presc_cnt++. Each value is therefore held presc+1 enabled cycles.
- Step, up: if idx >= eff_last, then the end is reached; otherwise idx+1.
- Step, down: if idx==0, then the end is reached; else if idx > eff_last, then idx <= eff_last; else idx-1.
- End, loop: idx <= (dir ? eff_last : 0), and wrap=1 for that cycle.
- End, one-shot: idx holds, state becomes IDLE, and done=1 for that cycle.
- seq_out timing: updated on the same edge as idx, to table[next idx]. If wr_en hits the next idx in the same cycle, wr_data is forwarded. seq_out == table[idx] always holds one edge later at worst; it never shows stale data past the next edge.
- Table writes are accepted in any state. Write takes effect at the clock edge.
- wrap and done default 0 every cycle and are never both 1.
- Changing last_idx, presc, dir or mode_loop mid-run takes effect at the next step decision. No glitch handling beyond the rules above.

Decomposition:
- Package seq_gen_pkg: state encoding constants (ST_IDLE=0, ST_RUN=1); clog2 function for AW.
- One sub-module: seq_table, a DEPTH x WIDTH register file with synchronous reset to identity, one write port and one combinational read port (address = next idx). seq_gen holds the FSM, prescaler, index logic and output registers.

Test Plan:
1. Reset, then start, with mode_loop=1, dir=0, presc=0, last_idx=7, en=1 -> seq_out 0,1,2,...,7,0 on successive cycles; wrap=1 only on the 7->0 step; running=1.
2. Write the table 0,4,1,3,6,2,7,5, then start with loop/up/presc=0 -> seq_out 0,4,1,3,6,2,7,5,0,4; wrap once per pass.
3. Same table with dir=1 -> seq_out 5,7,2,6,3,1,4,0,5.
4. Identity table, presc=2, one-shot, last_idx=3 -> each of 0,1,2,3 held 3 cycles; done=1 one cycle at the end; running->0; seq_out stays 3, idx stays 3.
5. Mid-run: en=0 for 4 cycles -> idx/seq_out frozen. Then start+stop in the same cycle -> IDLE, no done. Then rst -> idx=0, seq_out=0, table back to identity.
6. While RUN, write wr_addr = next idx with 3'h6 -> seq_out=6 on that step edge. Write to the current idx -> seq_out shows the new value by its next step.
